// File: rtl/pipe_fetch_decode.sv
// Fetch/decode stage: preloadable instruction memory, PC sequencing, 24-bit decode and local
// JMP/NOP/HALT handling. Define PIPE_FETCH_HAZARD_EN to compile in the RAW scoreboard interlock.
module pipe_fetch_decode #(
   parameter int PC_W       = 8,
   parameter int IMEM_DEPTH = 1 << PC_W,
   parameter int HAZ_DEPTH  = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic            load_en,
   input  logic [PC_W-1:0] load_addr,
   input  logic [23:0]     load_data,
   input  logic            out_ready,
   output logic [3:0]      func,
   output logic [3:0]      rd,
   output logic [3:0]      rs1,
   output logic [3:0]      rs2,
   output logic [7:0]      addr,
   output logic            issue_valid,
   output logic [PC_W-1:0] pc,
   output logic            halted,
   output logic            illegal
);
   typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT} state_t;

   localparam logic [3:0]      F_JMP  = 4'd12;
   localparam logic [3:0]      F_HALT = 4'd13;
   localparam logic [3:0]      F_NOP  = 4'd14;
   localparam logic [3:0]      F_ILL  = 4'd15;
   localparam logic [PC_W-1:0] PC_ONE = PC_W'(1);

   state_t          state_reg, state_next;
   logic [PC_W-1:0] pc_reg, pc_next, jmp_target;
   logic [23:0]     fields_reg, fields_next;
   logic            issue_valid_reg, issue_valid_next;
   logic            illegal_reg, illegal_next;
   logic [23:0]     imem [IMEM_DEPTH];
   logic [23:0]     instr;
   logic            hazard;
   logic            sb_clear, sb_shift, sb_push;

   // Program memory is writable only while the stage is not executing.
   always_ff @(posedge clk) begin
      if (load_en && state_reg != S_RUN)
         imem[load_addr] <= load_data;
   end

   assign instr = imem[pc_reg];

   generate
      if (PC_W <= 8) begin : g_jmp_narrow
         assign jmp_target = instr[PC_W-1:0];
      end else begin : g_jmp_wide
         assign jmp_target = {{(PC_W-8){1'b0}}, instr[7:0]};
      end
   endgenerate

`ifdef PIPE_FETCH_HAZARD_EN
   logic [HAZ_DEPTH-1:0] sb_valid_reg;
   logic [3:0]           sb_rd_reg [HAZ_DEPTH];
   logic [HAZ_DEPTH-1:0] sb_hit;
   genvar gi;

   // Both source fields are compared whatever the function actually reads.
   generate
      for (gi = 0; gi < HAZ_DEPTH; gi++) begin : g_sb_cmp
         assign sb_hit[gi] = sb_valid_reg[gi] &&
                             (sb_rd_reg[gi] == instr[15:12] || sb_rd_reg[gi] == instr[11:8]);
      end
   endgenerate

   assign hazard = |sb_hit;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sb_valid_reg <= '0;
         for (int i = 0; i < HAZ_DEPTH; i++)
            sb_rd_reg[i] <= 4'd0;
      end else if (sb_clear) begin
         sb_valid_reg <= '0;
      end else if (sb_shift) begin
         sb_valid_reg[0] <= sb_push;
         sb_rd_reg[0]    <= instr[19:16];
         for (int i = 1; i < HAZ_DEPTH; i++) begin
            sb_valid_reg[i] <= sb_valid_reg[i-1];
            sb_rd_reg[i]    <= sb_rd_reg[i-1];
         end
      end
   end
`else
   logic unused_sb;
   assign hazard    = 1'b0;
   assign unused_sb = ^{sb_clear, sb_shift, sb_push};
`endif

   always_comb begin
      state_next       = state_reg;
      pc_next          = pc_reg;
      fields_next      = fields_reg;
      issue_valid_next = 1'b0;
      illegal_next     = illegal_reg;
      sb_clear         = 1'b0;
      sb_shift         = 1'b0;
      sb_push          = 1'b0;
      case (state_reg)
         S_IDLE, S_HALT: begin
            if (start) begin
               state_next   = S_RUN;
               pc_next      = '0;
               illegal_next = 1'b0;
               sb_clear     = 1'b1;
            end
         end
         S_RUN: begin
            if (!out_ready) begin
               issue_valid_next = issue_valid_reg;
            end else begin
               sb_shift = 1'b1;
               case (instr[23:20])
                  F_JMP:  pc_next    = jmp_target;
                  F_HALT: state_next = S_HALT;
                  F_NOP:  pc_next    = pc_reg + PC_ONE;
                  F_ILL: begin
                     illegal_next = 1'b1;
                     state_next   = S_HALT;
                  end
                  default: begin
                     // A hazard leaves pc in place so the same word is re-fetched next cycle.
                     if (!hazard) begin
                        fields_next      = instr;
                        issue_valid_next = 1'b1;
                        pc_next          = pc_reg + PC_ONE;
                        sb_push          = 1'b1;
                     end
                  end
               endcase
            end
         end
         default: state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg       <= S_IDLE;
         pc_reg          <= '0;
         fields_reg      <= '0;
         issue_valid_reg <= 1'b0;
         illegal_reg     <= 1'b0;
      end else begin
         state_reg       <= state_next;
         pc_reg          <= pc_next;
         fields_reg      <= fields_next;
         issue_valid_reg <= issue_valid_next;
         illegal_reg     <= illegal_next;
      end
   end

   assign func        = fields_reg[23:20];
   assign rd          = fields_reg[19:16];
   assign rs1         = fields_reg[15:12];
   assign rs2         = fields_reg[11:8];
   assign addr        = fields_reg[7:0];
   assign issue_valid = issue_valid_reg;
   assign pc          = pc_reg;
   assign halted      = (state_reg == S_HALT);
   assign illegal     = illegal_reg;

endmodule
